adder_stimulus: RTL and testbench

Upstream stimulus and golden-reference source for the adder test bench. On `start`, it drives operand vectors into the adder under test: first a fixed corner-case set, then LFSR pseudo-random vectors. It computes the 17-bit expected sum and delays it through a LATENCY-deep pipeline so `ref` arrives at the result comparator in the same cycle as the adder's `result`. A small FSM sequences the run and reports busy/done.

---
 rtl/adder_stimulus.sv | 263 ++++++++++++++++++++++++++
 tb/tb_adder_stimulus.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_stimulus.sv
// ---------------------------------------------------------------------------
// adder_stimulus
//   Stimulus and golden-reference source for an adder under test. A start
//   pulse launches a run: eight fixed corner-case vectors, then NUM_RANDOM
//   vectors from two Galois LFSRs. The 17-bit expected sum of every issued
//   vector is carried through a LATENCY-deep pipeline, so ref_sum lines up
//   with the adder's result.
//
// Parameters
//   LATENCY    : adder pipeline depth, 1..8
//   NUM_RANDOM : random vectors after the corner set, 0..65527
//   SEED_A/B   : nonzero LFSR seeds, reloaded on every start
//
// Ports
//   clk       : clock, all state on posedge
//   rst       : asynchronous reset, active low
//   start     : single-cycle run request (ignored while busy)
//   a, b, cin : registered operands to the adder (0 outside issue cycles)
//   ref_sum   : expected {cout,sum}, aligned with the adder result
//   ref_valid : ref_sum holds a valid expected value
//   busy      : run in progress (CORNER, RANDOM or DRAIN)
//   done      : run finished, held until next start or reset
//   vec_count : vectors issued since the last start
//   inject    : (ADDER_STIM_ERR_INJECT_EN only) flip bit 0 of the ref
//               belonging to the vector issued in this cycle
//
// Optional feature macro: ADDER_STIM_ERR_INJECT_EN
// ---------------------------------------------------------------------------
module adder_stimulus #(
    parameter int          LATENCY    = 2,
    parameter int          NUM_RANDOM = 1024,
    parameter logic [15:0] SEED_A     = 16'hACE1,
    parameter logic [15:0] SEED_B     = 16'h1D87
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
`ifdef ADDER_STIM_ERR_INJECT_EN
    input  logic        inject,
`endif
    output logic [15:0] a,
    output logic [15:0] b,
    output logic        cin,
    output logic [16:0] ref_sum,
    output logic        ref_valid,
    output logic        busy,
    output logic        done,
    output logic [15:0] vec_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CORNER = 3'd1,
        S_RANDOM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [15:0] NUM_RANDOM_C = NUM_RANDOM[15:0];
    localparam logic [3:0]  LATENCY_C    = LATENCY[3:0];

    // Galois LFSR, x^16+x^14+x^13+x^11+1, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = {1'b0, s[15:1]} ^ ({16{s[0]}} & 16'hB400);
    endfunction

    // Fixed corner-case vector table, packed as {a, b, cin}.
    function automatic logic [32:0] corner_vec(input logic [2:0] idx);
        case (idx)
            3'd0:    corner_vec = {16'h0000, 16'h0000, 1'b0};
            3'd1:    corner_vec = {16'hFFFF, 16'h0001, 1'b0};
            3'd2:    corner_vec = {16'hFFFF, 16'hFFFF, 1'b1};
            3'd3:    corner_vec = {16'h8000, 16'h8000, 1'b0};
            3'd4:    corner_vec = {16'hAAAA, 16'h5555, 1'b0};
            3'd5:    corner_vec = {16'h5555, 16'hAAAA, 1'b1};
            3'd6:    corner_vec = {16'h0000, 16'h0000, 1'b1};
            3'd7:    corner_vec = {16'hFFFF, 16'h0000, 1'b1};
            default: corner_vec = {16'h0000, 16'h0000, 1'b0};
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;          // next corner index, 8 = set exhausted
    logic [15:0] rnd_cnt_q, rnd_cnt_d;  // random vectors issued so far
    logic [3:0]  drain_cnt_q, drain_cnt_d;
    logic [15:0] lfsr_a_q, lfsr_a_d;
    logic [15:0] lfsr_b_q, lfsr_b_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        cin_q, cin_d;
    logic        vld_q, vld_d;          // a_q/b_q/cin_q hold an issued vector
    logic        inj_q, inj_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] vec_count_q, vec_count_d;
    logic [16:0] pipe_q [LATENCY];
    logic [16:0] pipe_d [LATENCY];
    logic        pipe_vld_q [LATENCY];
    logic        pipe_vld_d [LATENCY];

    logic        issue_s;
    logic [32:0] vec_s;
    logic [16:0] exp_s;

    // Next-state, operand issue and expected-value pipeline.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rnd_cnt_d   = rnd_cnt_q;
        drain_cnt_d = drain_cnt_q;
        lfsr_a_d    = lfsr_a_q;
        lfsr_b_d    = lfsr_b_q;
        busy_d      = busy_q;
        done_d      = done_q;
        vec_count_d = vec_count_q;
        issue_s     = 1'b0;
        vec_s       = 33'd0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Corner vector 0 goes out on the same edge that enters CORNER.
                    state_d     = S_CORNER;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    lfsr_a_d    = SEED_A;
                    lfsr_b_d    = SEED_B;
                    rnd_cnt_d   = 16'd0;
                    idx_d       = 4'd1;
                    issue_s     = 1'b1;
                    vec_s       = corner_vec(3'd0);
                    vec_count_d = 16'd1;
                end else begin
                    state_d = state_q;
                end
            end
            S_CORNER: begin
                if (idx_q != 4'd8) begin
                    issue_s     = 1'b1;
                    vec_s       = corner_vec(idx_q[2:0]);
                    idx_d       = idx_q + 4'd1;
                    vec_count_d = vec_count_q + 16'd1;
                end else if (NUM_RANDOM_C != 16'd0) begin
                    state_d     = S_RANDOM;
                    issue_s     = 1'b1;
                    vec_s       = {lfsr_a_q, lfsr_b_q, lfsr_a_q[0] ^ lfsr_b_q[15]};
                    lfsr_a_d    = lfsr_step(lfsr_a_q);
                    lfsr_b_d    = lfsr_step(lfsr_b_q);
                    rnd_cnt_d   = 16'd1;
                    vec_count_d = vec_count_q + 16'd1;
                end else begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = 4'd1;
                end
            end
            S_RANDOM: begin
                if (rnd_cnt_q < NUM_RANDOM_C) begin
                    issue_s     = 1'b1;
                    vec_s       = {lfsr_a_q, lfsr_b_q, lfsr_a_q[0] ^ lfsr_b_q[15]};
                    lfsr_a_d    = lfsr_step(lfsr_a_q);
                    lfsr_b_d    = lfsr_step(lfsr_b_q);
                    rnd_cnt_d   = rnd_cnt_q + 16'd1;
                    vec_count_d = vec_count_q + 16'd1;
                end else begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = 4'd1;
                end
            end
            S_DRAIN: begin
                // DRAIN occupies exactly LATENCY cycles, letting the last ref out.
                if (drain_cnt_q == LATENCY_C) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase

        a_d   = vec_s[32:17];
        b_d   = vec_s[16:1];
        cin_d = vec_s[0];
        vld_d = issue_s;
`ifdef ADDER_STIM_ERR_INJECT_EN
        inj_d = inject & issue_s;
`else
        inj_d = 1'b0;
`endif

        // Expected sum of the vector currently on a/b/cin; forced to 0 when idle.
        if (vld_q) begin
            exp_s = ({1'b0, a_q} + {1'b0, b_q} + {16'd0, cin_q}) ^ {16'd0, inj_q};
        end else begin
            exp_s = 17'd0;
        end

        pipe_d[0]     = exp_s;
        pipe_vld_d[0] = vld_q;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i]     = pipe_q[i-1];
            pipe_vld_d[i] = pipe_vld_q[i-1];
        end
    end

    // State, operand and pipeline registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 4'd0;
            rnd_cnt_q   <= 16'd0;
            drain_cnt_q <= 4'd0;
            lfsr_a_q    <= SEED_A;
            lfsr_b_q    <= SEED_B;
            a_q         <= 16'd0;
            b_q         <= 16'd0;
            cin_q       <= 1'b0;
            vld_q       <= 1'b0;
            inj_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vec_count_q <= 16'd0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i]     <= 17'd0;
                pipe_vld_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rnd_cnt_q   <= rnd_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            lfsr_a_q    <= lfsr_a_d;
            lfsr_b_q    <= lfsr_b_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            vld_q       <= vld_d;
            inj_q       <= inj_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vec_count_q <= vec_count_d;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i]     <= pipe_d[i];
                pipe_vld_q[i] <= pipe_vld_d[i];
            end
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign cin       = cin_q;
    assign ref_sum   = pipe_q[LATENCY-1];
    assign ref_valid = pipe_vld_q[LATENCY-1];
    assign busy      = busy_q;
    assign done      = done_q;
    assign vec_count = vec_count_q;

endmodule

// File: tb/tb_adder_stimulus.sv
module tb_adder_stimulus;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [16:0] exp;
    } vec_t;

    typedef struct {
        int          due;
        logic [16:0] exp;
    } sb_t;

    logic clk;
    logic rst;
    logic start0, start1, start2;

    // Three instances: (LATENCY 2, 16 random), (8, 3), (1, 0 = corner only).
    logic [15:0] a0, b0, vc0, a1, b1, vc1, a2, b2, vc2;
    logic        c0, rv0, bz0, dn0, c1, rv1, bz1, dn1, c2, rv2, bz2, dn2;
    logic [16:0] r0, r1, r2;

    adder_stimulus #(.LATENCY(2), .NUM_RANDOM(16)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
`ifdef ADDER_STIM_ERR_INJECT_EN
        .inject(1'b0),
`endif
        .a(a0), .b(b0), .cin(c0), .ref_sum(r0), .ref_valid(rv0),
        .busy(bz0), .done(dn0), .vec_count(vc0));

    adder_stimulus #(.LATENCY(8), .NUM_RANDOM(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
`ifdef ADDER_STIM_ERR_INJECT_EN
        .inject(1'b0),
`endif
        .a(a1), .b(b1), .cin(c1), .ref_sum(r1), .ref_valid(rv1),
        .busy(bz1), .done(dn1), .vec_count(vc1));

    adder_stimulus #(.LATENCY(1), .NUM_RANDOM(0)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
`ifdef ADDER_STIM_ERR_INJECT_EN
        .inject(1'b0),
`endif
        .a(a2), .b(b2), .cin(c2), .ref_sum(r2), .ref_valid(rv2),
        .busy(bz2), .done(dn2), .vec_count(vc2));

    // Observation mux selected by the test sequence.
    int          sel;
    logic [15:0] o_a, o_b, o_vc;
    logic        o_c, o_rv, o_bz, o_dn;
    logic [16:0] o_r;
    assign o_a  = (sel == 0) ? a0  : (sel == 1) ? a1  : a2;
    assign o_b  = (sel == 0) ? b0  : (sel == 1) ? b1  : b2;
    assign o_c  = (sel == 0) ? c0  : (sel == 1) ? c1  : c2;
    assign o_r  = (sel == 0) ? r0  : (sel == 1) ? r1  : r2;
    assign o_rv = (sel == 0) ? rv0 : (sel == 1) ? rv1 : rv2;
    assign o_bz = (sel == 0) ? bz0 : (sel == 1) ? bz1 : bz2;
    assign o_dn = (sel == 0) ? dn0 : (sel == 1) ? dn1 : dn2;
    assign o_vc = (sel == 0) ? vc0 : (sel == 1) ? vc1 : vc2;

    int   cmp_cnt;
    int   fail_cnt;
    vec_t corner_tbl [8];
    sb_t  sbq [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        cmp_cnt++;
        if (act !== expv) begin
            fail_cnt++;
            $display("FAIL %s (dut%0d, t=%0t): got %0h, expected %0h", nm, sel, $time, act, expv);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    task automatic set_start(input logic v);
        if (sel == 0) start0 = v;
        else if (sel == 1) start1 = v;
        else start2 = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a"}, {16'd0, o_a}, 32'd0);
        chk({tag, "_b"}, {16'd0, o_b}, 32'd0);
        chk({tag, "_cin"}, {31'd0, o_c}, 32'd0);
        chk({tag, "_ref"}, {15'd0, o_r}, 32'd0);
        chk({tag, "_ref_valid"}, {31'd0, o_rv}, 32'd0);
        chk({tag, "_busy"}, {31'd0, o_bz}, 32'd0);
        chk({tag, "_done"}, {31'd0, o_dn}, 32'd0);
        chk({tag, "_vec_count"}, {16'd0, o_vc}, 32'd0);
    endtask

    // One full run on the selected instance, checked edge by edge.
    // ign_k > 0 raises start after edge ign_k (sampled while busy).
    task automatic run_check(input int lat, input int nr, input int ign_k);
        logic [15:0] la, lb;
        vec_t        v;
        sb_t         e;
        int          nvec, last;
        la   = 16'hACE1;
        lb   = 16'h1D87;
        nvec = 8 + nr;
        last = nvec + lat + 1;
        sbq.delete();
        @(negedge clk);
        set_start(1'b1);
        for (int k = 1; k <= last; k++) begin
            @(posedge clk);
            #1;
            set_start((k == ign_k) ? 1'b1 : 1'b0);
            if (k <= nvec) begin
                if (k <= 8) begin
                    v = corner_tbl[k-1];
                end else begin
                    v.a   = la;
                    v.b   = lb;
                    v.cin = la[0] ^ lb[15];
                    v.exp = {1'b0, la} + {1'b0, lb} + {16'd0, v.cin};
                    la    = lfsr_next(la);
                    lb    = lfsr_next(lb);
                end
                chk("issue_a", {16'd0, o_a}, {16'd0, v.a});
                chk("issue_b", {16'd0, o_b}, {16'd0, v.b});
                chk("issue_cin", {31'd0, o_c}, {31'd0, v.cin});
                chk("vec_count", {16'd0, o_vc}, k);
                e.due = k + lat;
                e.exp = v.exp;
                sbq.push_back(e);
            end else begin
                chk("idle_operands", {15'd0, o_c, o_a}, 32'd0);
                chk("idle_b", {16'd0, o_b}, 32'd0);
            end
            if (sbq.size() > 0 && sbq[0].due == k) begin
                e = sbq.pop_front();
                chk("ref_valid", {31'd0, o_rv}, 32'd1);
                chk("ref", {15'd0, o_r}, {15'd0, e.exp});
            end else begin
                chk("ref_valid_low", {31'd0, o_rv}, 32'd0);
                chk("ref_zero", {15'd0, o_r}, 32'd0);
            end
            chk("busy", {31'd0, o_bz}, (k < last) ? 32'd1 : 32'd0);
            chk("done", {31'd0, o_dn}, (k < last) ? 32'd0 : 32'd1);
        end
        chk("final_vec_count", {16'd0, o_vc}, nvec);
        chk("scoreboard_empty", sbq.size(), 32'd0);
    endtask

    initial begin
        cmp_cnt  = 0;
        fail_cnt = 0;
        sel      = 0;
        start0   = 1'b0;
        start1   = 1'b0;
        start2   = 1'b0;
        rst      = 1'b0;

        corner_tbl[0] = '{16'h0000, 16'h0000, 1'b0, 17'h00000};
        corner_tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000};
        corner_tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
        corner_tbl[3] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
        corner_tbl[4] = '{16'hAAAA, 16'h5555, 1'b0, 17'h0FFFF};
        corner_tbl[5] = '{16'h5555, 16'hAAAA, 1'b1, 17'h10000};
        corner_tbl[6] = '{16'h0000, 16'h0000, 1'b1, 17'h00001};
        corner_tbl[7] = '{16'hFFFF, 16'h0000, 1'b1, 17'h10000};

        // Reset held for 3 cycles, then 10 idle cycles without start.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            chk_all_zero("reset_idle");
        end

        // Corner + random run with an ignored start mid-RANDOM, then a rerun from DONE.
        sel = 0;
        run_check(2, 16, 12);
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", {31'd0, o_dn}, 32'd1);
        chk("done_held_count", {16'd0, o_vc}, 32'd24);
        run_check(2, 16, 0);

        // Latency extremes; the LATENCY=1 instance is corner-only.
        sel = 1;
        run_check(8, 3, 0);
        sel = 2;
        run_check(1, 0, 0);

        // Asynchronous reset in the middle of RANDOM, then a clean restart.
        sel = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (11) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        rst = 1'b1;
        run_check(2, 16, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
